// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial converter.
package serial_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } serial_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_if.sv
// Word handshake in, strobed bit stream out.
interface serial_if #(
  parameter int unsigned p_width = 8
);
  logic [p_width-1:0] i_dat;
  logic               i_vld;
  logic               o_rdy;
  logic               o_val;
  logic               o_stp;
  logic               o_lst;
  logic               o_bsy;

  modport master (
    output i_dat, i_vld,
    input  o_rdy, o_val, o_stp, o_lst, o_bsy
  );

  modport slave (
    input  i_dat, i_vld,
    output o_rdy, o_val, o_stp, o_lst, o_bsy
  );
endinterface

// File: rtl/serial_tick_div.sv
// Bit-period prescaler: tick_c flags the last cycle of every p_div-cycle period.
module serial_tick_div
  import serial_pkg::*;
#(
  parameter int unsigned p_div = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned PW = cnt_width(p_div);
  localparam logic [PW-1:0] LAST = PW'(p_div - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  assign tick_c = (cnt == LAST);

endmodule

// File: rtl/serial.sv
// Parallel-to-serial converter, MSB first, with a one-word holding buffer
// so that back-to-back frames leave no gap on the bit stream.
module serial
  import serial_pkg::*;
#(
  parameter int unsigned p_width = 8,
  parameter int unsigned p_div   = 1
) (
  input  logic     i_clk,
  input  logic     i_rst,
  serial_if.slave  bus
);

  localparam int unsigned CW = cnt_width(p_width);
  localparam logic [CW-1:0] BIT_LAST   = CW'(p_width - 1);
  localparam logic [CW-1:0] BIT_PENULT = CW'(p_width - 2);

  serial_state_t      state;
  logic [p_width-1:0] buf_dat;
  logic [p_width-1:0] shr;
  logic [CW-1:0]      bit_cnt;
  logic               rdy;
  logic               val;
  logic               stp;
  logic               lst;
  logic               bsy;

  logic tick_c;
  logic clr_c;
  logic accept_c;
  logic frame_end_c;
  logic load_c;

  // Prescaler held at zero while idle so each frame starts on a fresh period
  assign clr_c = (state == IDLE);

  serial_tick_div #(.p_div(p_div)) u_tick (
    .clk    (i_clk),
    .rst_n  (i_rst),
    .clr    (clr_c),
    .tick_c (tick_c)
  );

  assign accept_c    = bus.i_vld & rdy;
  assign frame_end_c = (state == SHIFT) & tick_c & (bit_cnt == BIT_LAST);
  assign load_c      = !rdy & ((state == IDLE) | frame_end_c);

  // Holding buffer; rdy doubles as the "buffer empty" flag
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      buf_dat <= '0;
      rdy     <= 1'b1;
    end else if (accept_c) begin
      buf_dat <= bus.i_dat;
      rdy     <= 1'b0;
    end else if (load_c) begin
      rdy     <= 1'b1;
    end
  end

  // Shifter FSM: loads from the buffer, then walks one bit per period
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= IDLE;
      shr     <= '0;
      bit_cnt <= '0;
      val     <= 1'b0;
      stp     <= 1'b0;
      lst     <= 1'b0;
      bsy     <= 1'b0;
    end else begin
      stp <= 1'b0;
      lst <= 1'b0;
      if (load_c) begin
        state   <= SHIFT;
        shr     <= buf_dat << 1;
        val     <= buf_dat[p_width-1];
        bit_cnt <= '0;
        stp     <= 1'b1;
        bsy     <= 1'b1;
      end else if (frame_end_c) begin
        state   <= IDLE;
        val     <= 1'b0;
        bit_cnt <= '0;
        bsy     <= 1'b0;
      end else if (state == SHIFT && tick_c) begin
        shr     <= shr << 1;
        val     <= shr[p_width-1];
        bit_cnt <= bit_cnt + CW'(1);
        stp     <= 1'b1;
        lst     <= (bit_cnt == BIT_PENULT);
      end
    end
  end

  assign bus.o_rdy = rdy;
  assign bus.o_val = val;
  assign bus.o_stp = stp;
  assign bus.o_lst = lst;
  assign bus.o_bsy = bsy;

endmodule

// File: tb/tb_serial.sv
// Bench for serial: three instances (p_div 1, 4, 3), a receiver model that
// reassembles frames and checks them against the accepted-word queue.
module tb_serial;

  localparam int unsigned W    = 8;
  localparam int unsigned NI   = 3;
  localparam int unsigned DIV0 = 1;
  localparam int unsigned DIV1 = 4;
  localparam int unsigned DIV2 = 3;

  function automatic int div_of(input int g);
    case (g)
      0:       return int'(DIV0);
      1:       return int'(DIV1);
      default: return int'(DIV2);
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [W-1:0]  dat [NI];
  logic [NI-1:0] vld;
  logic [NI-1:0] rdy, val, stp, lst, bsy;

  serial_if #(.p_width(W)) if0 ();
  serial_if #(.p_width(W)) if1 ();
  serial_if #(.p_width(W)) if2 ();

  assign if0.i_dat = dat[0];
  assign if0.i_vld = vld[0];
  assign if1.i_dat = dat[1];
  assign if1.i_vld = vld[1];
  assign if2.i_dat = dat[2];
  assign if2.i_vld = vld[2];

  assign rdy = {if2.o_rdy, if1.o_rdy, if0.o_rdy};
  assign val = {if2.o_val, if1.o_val, if0.o_val};
  assign stp = {if2.o_stp, if1.o_stp, if0.o_stp};
  assign lst = {if2.o_lst, if1.o_lst, if0.o_lst};
  assign bsy = {if2.o_bsy, if1.o_bsy, if0.o_bsy};

  serial #(.p_width(W), .p_div(DIV0)) u_s0 (.i_clk(clk), .i_rst(rst_n), .bus(if0.slave));
  serial #(.p_width(W), .p_div(DIV1)) u_s1 (.i_clk(clk), .i_rst(rst_n), .bus(if1.slave));
  serial #(.p_width(W), .p_div(DIV2)) u_s2 (.i_clk(clk), .i_rst(rst_n), .bus(if2.slave));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", name, g, act, req);
    end
  endtask

  // Receiver model: queue of accepted words, reassembly of strobed bits
  logic [W-1:0] exp_mem [NI][256];
  logic [7:0]   wr [NI];
  logic [7:0]   rd [NI];
  int           rx_n [NI];
  int           gap [NI];
  int           rx_words [NI];
  logic [W-1:0] rx_sh [NI];
  logic         held [NI];

  always @(negedge clk) begin
    for (int g = 0; g < int'(NI); g++) begin
      if (!rst_n) begin
        rd[g]   = wr[g];
        rx_n[g] = 0;
      end else begin
        if (vld[g] && rdy[g]) begin
          exp_mem[g][wr[g]] = dat[g];
          wr[g]++;
        end
        if (!bsy[g]) begin
          check("idle_quiet", g, 32'({stp[g], val[g], lst[g]}), 32'h0);
        end else if (stp[g]) begin
          if (rx_n[g] > 0) check("bit_period", g, 32'(gap[g]), 32'(div_of(g)));
          gap[g]   = 1;
          held[g]  = val[g];
          rx_sh[g] = {rx_sh[g][W-2:0], val[g]};
          rx_n[g]++;
          check("lst_pos", g, 32'(lst[g]), 32'(rx_n[g] == int'(W)));
          if (rx_n[g] >= int'(W)) begin
            check("frame_pending", g, 32'(wr[g] != rd[g]), 32'h1);
            check("frame_word", g, 32'(rx_sh[g]), 32'(exp_mem[g][rd[g]]));
            rd[g]++;
            rx_words[g]++;
            rx_n[g] = 0;
          end
        end else begin
          gap[g]++;
          check("val_hold", g, 32'({val[g], lst[g]}), 32'({held[g], 1'b0}));
        end
      end
    end
  end

  // Offer a word and hold it until accepted; returns just after the accept edge
  task automatic send(input int g, input logic [W-1:0] w);
    logic acc;
    acc    = 1'b0;
    dat[g] = w;
    vld[g] = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      acc = rdy[g];
      @(posedge clk);
      #1;
    end
    vld[g] = 1'b0;
    check("accept_timeout", g, 32'(acc), 32'h1);
  endtask

  // Record strobes over a fixed window; c=1 is the cycle after the accept edge
  task automatic capture(input int g, input int window, output logic [31:0] bits,
                         output int nstp, output int first_c, output int last_c,
                         output logic [31:0] lmask, output int nbsy);
    bits = '0; nstp = 0; first_c = -1; last_c = -1; lmask = '0; nbsy = 0;
    for (int c = 1; c <= window; c++) begin
      @(negedge clk);
      if (bsy[g]) nbsy++;
      if (stp[g]) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        bits   = {bits[30:0], val[g]};
        if (lst[g] && nstp < 32) lmask[nstp] = 1'b1;
        nstp++;
      end
    end
  endtask

  typedef struct {
    int           g;
    logic [W-1:0] w;
    int           nstp;
    int           first;
    int           span;
    int           nbsy;
  } vec_t;

  vec_t        tbl [5];
  logic [31:0] bits, lmask;
  int          nstp, first_c, last_c, nbsy, n;
  int          base0, base2;

  initial begin
    rst_n = 1'b0;
    vld   = '0;
    for (int g = 0; g < int'(NI); g++) begin
      dat[g] = '0; wr[g] = '0; rd[g] = '0; rx_n[g] = 0; gap[g] = 0;
      rx_words[g] = 0; rx_sh[g] = '0; held[g] = 1'b0;
    end

    // Frame: strobes start in the 2nd cycle after accept, one per p_div cycles
    tbl[0] = '{0, 8'hA5, 8, 2, 7,  8};
    tbl[1] = '{0, 8'h00, 8, 2, 7,  8};
    tbl[2] = '{0, 8'hFF, 8, 2, 7,  8};
    tbl[3] = '{1, 8'h81, 8, 2, 28, 32};
    tbl[4] = '{2, 8'h5A, 8, 2, 21, 24};

    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", 0, 32'(rdy), 32'h7);
    check("rst_outs", 0, 32'({val, stp, lst, bsy}), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      send(tbl[i].g, tbl[i].w);
      capture(tbl[i].g, 40, bits, nstp, first_c, last_c, lmask, nbsy);
      check("vec_nstp",  i, 32'(nstp), 32'(tbl[i].nstp));
      check("vec_bits",  i, bits, 32'(tbl[i].w));
      check("vec_first", i, 32'(first_c), 32'(tbl[i].first));
      check("vec_span",  i, 32'(last_c - first_c), 32'(tbl[i].span));
      check("vec_lst",   i, lmask, 32'h80);
      check("vec_bsy",   i, 32'(nbsy), 32'(tbl[i].nbsy));
      @(posedge clk);
      #1;
    end

    // Back-to-back: second word accepted while the first is shifting
    send(0, 8'hA5);
    fork
      send(0, 8'h3C);
      capture(0, 30, bits, nstp, first_c, last_c, lmask, nbsy);
    join
    check("b2b_nstp", 0, 32'(nstp), 32'd16);
    check("b2b_bits", 0, bits, 32'h0000A53C);
    check("b2b_span", 0, 32'(last_c - first_c), 32'd15);
    check("b2b_lst",  0, lmask, 32'h8080);
    check("b2b_bsy",  0, 32'(nbsy), 32'd16);
    @(posedge clk);
    #1;

    // Reset in the middle of a frame
    send(0, 8'hFF);
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      if (stp[0]) n++;
    end
    check("pre_rst_strobes", 0, 32'(n), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", 0, 32'({val[0], stp[0], lst[0], bsy[0], rdy[0]}), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    capture(0, 20, bits, nstp, first_c, last_c, lmask, nbsy);
    check("post_rst_quiet", 0, 32'(nstp + nbsy), 32'h0);
    @(posedge clk);
    #1;
    send(0, 8'h0F);
    capture(0, 14, bits, nstp, first_c, last_c, lmask, nbsy);
    check("post_rst_nstp", 0, 32'(nstp), 32'd8);
    check("post_rst_bits", 0, bits, 32'h0F);
    check("post_rst_lst",  0, lmask, 32'h80);
    @(posedge clk);
    #1;

    // Random loopback on p_div=1 and p_div=3
    base0 = rx_words[0];
    base2 = rx_words[2];
    fork
      for (int k = 0; k < 100; k++) begin
        int gp;
        send(0, W'($urandom()));
        gp = int'($urandom_range(0, 4));
        if (gp > 0) begin
          repeat (gp) @(posedge clk);
          #1;
        end
      end
      for (int k = 0; k < 100; k++) begin
        int gp;
        send(2, W'($urandom()));
        gp = int'($urandom_range(0, 4));
        if (gp > 0) begin
          repeat (gp) @(posedge clk);
          #1;
        end
      end
    join
    for (int c = 0; c < 500 && (rd[0] != wr[0] || rd[2] != wr[2] || bsy != '0); c++) begin
      @(negedge clk);
    end
    check("rand_words", 0, 32'(rx_words[0] - base0), 32'd100);
    check("rand_words", 2, 32'(rx_words[2] - base2), 32'd100);
    check("rand_drained", 0, 32'(wr[0] - rd[0]), 32'h0);
    check("rand_drained", 2, 32'(wr[2] - rd[2]), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
